// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction constants, word-address
// width helper and the IF/ID pipeline bundle.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  function automatic int waddr_w(input int bytes);
    return $clog2(bytes / INSTR_BYTES);
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        oob;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory bus: imem_addr (byte address, master drives),
// imem_instr (word returned combinationally, slave drives).
interface if_stage_if;
  import mips_pkg::*;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (
    output imem_addr,
    input  imem_instr
  );

  modport slave (
    input  imem_addr,
    output imem_instr
  );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter: register, redirect/stall/increment mux, +4 adder.
// Ports: clk, rst_n, stall, redirect, redirect_target -> pc, pc4.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc  = pc_q;
  assign pc4 = pc_q + 32'(INSTR_BYTES);

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect:
        pc_d = redirect_target & ~32'd3;
      (!redirect && !stall):
        pc_d = pc4;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns PC (via pc_reg), drives imem bus, registers IF/ID.
// Ports: clk, rst_n, stall, redirect, redirect_target, imem (master),
// if_id_instr/pc/pc4/valid, fetch_oob; perf_fetched/perf_bubbles when
// IF_PERF_CNT_EN is defined.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  if_stage_if.master        imem,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid,
  output logic              fetch_oob
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - INSTR_BYTES);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic        oob;
  logic        cap;
  if_id_t      q;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc4             (pc4)
  );

  assign imem.imem_addr = pc;
  assign oob = pc > LAST_ADDR;
  assign cap = !redirect && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{instr: NOP_INSTR, default: '0};
    end else begin
      unique case (1'b1)
        redirect: begin
          // squash wrong-path word; pc/pc4 keep last real values
          q.instr <= NOP_INSTR;
          q.valid <= 1'b0;
          q.oob   <= 1'b0;
        end
        cap: begin
          q.pc    <= pc;
          q.pc4   <= pc4;
          q.instr <= oob ? NOP_INSTR : imem.imem_instr;
          q.valid <= !oob;
          q.oob   <= oob;
        end
        default: ;
      endcase
    end
  end

  assign if_id_instr = q.instr;
  assign if_id_pc    = q.pc;
  assign if_id_pc4   = q.pc4;
  assign if_id_valid = q.valid;
  assign fetch_oob   = q.oob;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (cap && !oob)
        perf_fetched <= perf_fetched + 32'd1;
      if (redirect || (cap && oob))
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: reference model feeds a scoreboard
// queue of expected IF/ID + imem_addr values, popped after each edge.
module tb_if_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        oob;
  } obs_t;

  localparam int WA = waddr_w(1024);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
  logic        if_id_valid, fetch_oob;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  logic [31:0] mem [0:(1<<WA)-1];
  logic [31:0] prog [0:2];

  if_stage_if bus ();

  assign bus.imem_instr = (bus.imem_addr < 32'd1024) ?
    mem[bus.imem_addr[9:2]] : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (1024)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (tgt),
    .imem            (bus),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .fetch_oob       (fetch_oob)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  obs_t q[$];
  logic [31:0] m_pc;
  obs_t m_out;
  int m_fet, m_bub;
  obs_t got, exp_o;

  function automatic obs_t obs();
    return '{bus.imem_addr, if_id_instr, if_id_pc,
             if_id_pc4, if_id_valid, fetch_oob};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_out = '{default: '0};
    m_fet = 0;
    m_bub = 0;
    q.delete();
  endtask

  task automatic model_edge(input bit s, input bit r,
                            input logic [31:0] t);
    obs_t o;
    o = m_out;
    if (r) begin
      o.instr = 32'h0; o.valid = 1'b0; o.oob = 1'b0;
      m_pc = {t[31:2], 2'b00};
      m_bub++;
    end else if (!s) begin
      o.pc = m_pc;
      o.pc4 = m_pc + 32'd4;
      if (m_pc > 32'd1020) begin
        o.instr = 32'h0; o.valid = 1'b0; o.oob = 1'b1;
        m_bub++;
      end else begin
        o.instr = mem[m_pc[9:2]]; o.valid = 1'b1; o.oob = 1'b0;
        m_fet++;
      end
      m_pc = m_pc + 32'd4;
    end
    o.addr = m_pc;
    m_out = o;
    q.push_back(o);
  endtask

  task automatic drive(input bit s, input bit r,
                       input logic [31:0] t);
    model_edge(s, r, t);
    stall = s; redirect = r; tgt = t;
    @(posedge clk);
    #1;
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b1; redirect = 1'b1; tgt = 32'h80;
    @(posedge clk); #1;
    got = obs();
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_state got=%h want=0", got);
    end
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      exp_o = q.pop_front(); got = obs();
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL sb_fetch%0d got=%h want=%h", i, got, exp_o);
      end
      n_cmp++;
      if (if_id_pc !== 32'(4*i) || if_id_instr !== prog[i] ||
          bus.imem_addr !== 32'(4*i+4) || if_id_valid !== 1'b1) begin
        n_err++;
        $display("FAIL fetch%0d pc=%h instr=%h addr=%h v=%b",
                 i, if_id_pc, if_id_instr, bus.imem_addr, if_id_valid);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i == 2 || i == 3, 1'b0, 32'h0);
      exp_o = q.pop_front(); got = obs();
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL sb_stall%0d got=%h want=%h", i, got, exp_o);
      end
      if (i == 2 || i == 3) begin
        n_cmp++;
        if (bus.imem_addr !== 32'h8 || if_id_pc !== 32'h4 ||
            if_id_instr !== prog[1] || if_id_valid !== 1'b1) begin
          n_err++;
          $display("FAIL stall_hold%0d addr=%h pc=%h instr=%h",
                   i, bus.imem_addr, if_id_pc, if_id_instr);
        end
      end
    end
    n_cmp++;
    if (if_id_pc !== 32'h8 || if_id_instr !== prog[2]) begin
      n_err++;
      $display("FAIL stall_release pc=%h instr=%h want 8/%h",
               if_id_pc, if_id_instr, prog[2]);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    drive(1'b0, 1'b0, 32'h0);
    void'(q.pop_front());
    drive(1'b1, 1'b1, 32'h0000_0043);
    exp_o = q.pop_front(); got = obs();
    n_cmp++;
    if (got !== exp_o) begin
      n_err++;
      $display("FAIL sb_redir got=%h want=%h", got, exp_o);
    end
    n_cmp++;
    if (bus.imem_addr !== 32'h40 || if_id_valid !== 1'b0 ||
        if_id_instr !== 32'h0) begin
      n_err++;
      $display("FAIL redir_bubble addr=%h v=%b instr=%h",
               bus.imem_addr, if_id_valid, if_id_instr);
    end
    drive(1'b0, 1'b0, 32'h0);
    exp_o = q.pop_front(); got = obs();
    n_cmp++;
    if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 ||
        if_id_instr !== mem[16] || got !== exp_o) begin
      n_err++;
      $display("FAIL redir_target got=%h want=%h", got, exp_o);
    end
  endtask

  task automatic test_oob();
    bit s [7];
    bit r [7];
    logic [31:0] t [7];
    s = '{0, 0, 0, 1, 0, 0, 0};
    r = '{1, 0, 0, 0, 0, 1, 0};
    t = '{32'h3FC, 0, 0, 0, 0, 32'h8, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(s[i], r[i], t[i]);
      exp_o = q.pop_front(); got = obs();
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL sb_oob%0d got=%h want=%h", i, got, exp_o);
      end
      if (i == 1) begin
        n_cmp++;
        if (if_id_pc !== 32'h3FC || fetch_oob !== 1'b0 ||
            if_id_valid !== 1'b1 || if_id_instr !== mem[255]) begin
          n_err++;
          $display("FAIL oob_last pc=%h oob=%b v=%b",
                   if_id_pc, fetch_oob, if_id_valid);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (if_id_pc !== 32'h400 || fetch_oob !== 1'b1 ||
            if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
          n_err++;
          $display("FAIL oob_first pc=%h oob=%b v=%b instr=%h",
                   if_id_pc, fetch_oob, if_id_valid, if_id_instr);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (fetch_oob !== 1'b0) begin
          n_err++;
          $display("FAIL oob_clear_redir oob=%b want 0", fetch_oob);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i == 0, 32'hFFFF_FFFF);
      exp_o = q.pop_front(); got = obs();
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL sb_wrap%0d got=%h want=%h", i, got, exp_o);
      end
    end
    n_cmp++;
    if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 ||
        bus.imem_addr !== 32'h4) begin
      n_err++;
      $display("FAIL wrap pc=%h v=%b addr=%h", if_id_pc,
               if_id_valid, bus.imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, 1'b1, 32'h100);
    drive(1'b0, 1'b1, 32'h200);
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_o = q.pop_front();
      if (i == 2) begin
        got = obs();
        n_cmp++;
        if (got !== exp_o || if_id_pc !== 32'h200 ||
            if_id_valid !== 1'b1) begin
          n_err++;
          $display("FAIL b2b got=%h want=%h", got, exp_o);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 32'h0);
    q.delete();
    n_cmp++;
    if (bus.imem_addr !== 32'h20) begin
      n_err++;
      $display("FAIL pre_async addr=%h want 20", bus.imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_err++;
      $display("FAIL async_reset got=%h want=0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 32'h0);
    exp_o = q.pop_front(); got = obs();
    n_cmp++;
    if (got !== exp_o || if_id_pc !== 32'h0 ||
        if_id_instr !== prog[0]) begin
      n_err++;
      $display("FAIL post_reset got=%h want=%h", got, exp_o);
    end
  endtask

  task automatic test_random();
    bit s, r;
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 6) == 0);
      t = ($urandom_range(0, 4) == 0) ? 32'($urandom) :
          32'($urandom_range(0, 1060));
      drive(s, r, t);
      exp_o = q.pop_front(); got = obs();
      n_cmp++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL sb_rand%0d got=%h want=%h", i, got, exp_o);
      end
    end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h10);
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    q.delete();
    n_cmp++;
    if (perf_fetched !== 32'd5 || perf_bubbles !== 32'd1 ||
        perf_fetched !== 32'(m_fet) || perf_bubbles !== 32'(m_bub)) begin
      n_err++;
      $display("FAIL perf fetched=%0d bubbles=%0d want 5/1",
               perf_fetched, perf_bubbles);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << WA); i++)
      mem[i] = 32'hA000_0000 | 32'(i);
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0003;
    prog[2] = 32'h0109_5020;
    for (int i = 0; i < 3; i++) mem[i] = prog[i];
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_stall();
    test_oob();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
